// File: rtl/am_rx_pkg.sv
// Shared types and helpers for the AM receiver control path.
package am_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int SAMPLE_W = 12;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Magnitude of a sign-extended w-bit value; the most negative code clamps
  // to the largest positive code so the result always fits in w-1 bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                          input int unsigned w);
    logic [31:0] mag;
    logic [31:0] lim;
    lim = (32'd1 << (w - 1)) - 32'd1;
    mag = x[31] ? 32'(-x) : 32'(x);
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/am_peak_window.sv
// Windowed peak-magnitude tracker: counts 2^WIN_LOG2 samples and strobes done
// on the last one, presenting the peak including that sample.
module am_peak_window
  import am_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int WIN_LOG2   = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         clear_i,
  output logic [DATA_WIDTH-1:0]        peak_o,
  output logic                         done_o
);

  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] peak_q, peak_d;
  logic [DATA_WIDTH-1:0] mag;

  assign mag    = DATA_WIDTH'(sat_abs(32'(sample_i), DATA_WIDTH));
  assign peak_o = (valid_i && (mag > peak_q)) ? mag : peak_q;
  assign done_o = valid_i && (cnt_q == '1);

  always_comb begin
    cnt_d  = cnt_q;
    peak_d = peak_q;
    if (clear_i) begin
      cnt_d  = '0;
      peak_d = '0;
    end else if (valid_i) begin
      // Counter wraps to zero on the window-ending sample.
      cnt_d  = cnt_q + WIN_LOG2'(1);
      peak_d = done_o ? '0 : peak_o;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt_q  <= '0;
      peak_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      peak_q <= peak_d;
    end
  end

endmodule

// File: rtl/am_tune_agc_ctrl.sv
// Retune sequencer, windowed-peak AGC and settle blanking for the AM receiver.
module am_tune_agc_ctrl
  import am_rx_pkg::*;
#(
  parameter int PHASE_WIDTH    = 64,
  parameter int DATA_WIDTH     = 12,
  parameter int CIC_GAIN_WIDTH = 2,
  parameter int GAIN_INIT      = 1,
  parameter int SETTLE_SAMPLES = 8,
  parameter int WIN_LOG2       = 4,
  parameter int AGC_HI         = 1536,
  parameter int AGC_LO         = 384
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         tune_req,
  input  logic [PHASE_WIDTH-1:0]       tune_phase_inc,
  output logic                         tune_ready,
  output logic [PHASE_WIDTH-1:0]       phase_increment,
  output logic [CIC_GAIN_WIDTH-1:0]    cic_gain,
  input  logic                         demod_valid,
  input  logic signed [DATA_WIDTH-1:0] demod,
  output logic                         audio_valid,
  output logic signed [DATA_WIDTH-1:0] audio,
  output logic                         locked
);

  localparam int SC_W = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [SC_W-1:0]           SETTLE_LAST = SC_W'(SETTLE_SAMPLES - 1);
  localparam logic [CIC_GAIN_WIDTH-1:0] GAIN_RST    = CIC_GAIN_WIDTH'(GAIN_INIT);
  localparam logic [CIC_GAIN_WIDTH-1:0] GAIN_MAX    = '1;
  localparam logic [CIC_GAIN_WIDTH-1:0] GAIN_ONE    = CIC_GAIN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]     HI_TH       = DATA_WIDTH'(AGC_HI);
  localparam logic [DATA_WIDTH-1:0]     LO_TH       = DATA_WIDTH'(AGC_LO);

  state_e                        state_q;
  logic [SC_W-1:0]               settle_cnt_q;
  logic [PHASE_WIDTH-1:0]        phase_q;
  logic [CIC_GAIN_WIDTH-1:0]     gain_q;
  logic                          ready_q;
  logic                          locked_q;
  logic                          av_q;
  logic signed [DATA_WIDTH-1:0]  audio_q;

  logic                  accept;
  logic                  run_vld;
  logic                  win_done;
  logic [DATA_WIDTH-1:0] win_peak;

  assign accept  = tune_req && ready_q;
  assign run_vld = demod_valid && (state_q == ST_RUN);

  am_peak_window #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LOG2   (WIN_LOG2)
  ) u_win (
    .clk      (clk),
    .arst     (arst),
    .valid_i  (run_vld),
    .sample_i (demod),
    .clear_i  (accept),
    .peak_o   (win_peak),
    .done_o   (win_done)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      phase_q      <= '0;
      gain_q       <= GAIN_RST;
      ready_q      <= 1'b1;
      locked_q     <= 1'b0;
      av_q         <= 1'b0;
      audio_q      <= '0;
    end else begin
      av_q <= run_vld;
      if (run_vld) audio_q <= demod;

      // A retune overrides any window evaluation landing on the same edge.
      if (accept) begin
        phase_q      <= tune_phase_inc;
        gain_q       <= GAIN_RST;
        locked_q     <= 1'b0;
        settle_cnt_q <= '0;
        state_q      <= ST_SETTLE;
        ready_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (demod_valid) begin
              if (settle_cnt_q == SETTLE_LAST) begin
                settle_cnt_q <= '0;
                state_q      <= ST_RUN;
                ready_q      <= 1'b1;
              end else begin
                settle_cnt_q <= settle_cnt_q + SC_W'(1);
              end
            end
          end
          ST_RUN: begin
            if (win_done) begin
              if ((win_peak >= HI_TH) && (gain_q != '0)) begin
                gain_q   <= gain_q - GAIN_ONE;
                locked_q <= 1'b0;
                state_q  <= ST_SETTLE;
                ready_q  <= 1'b0;
              end else if ((win_peak < LO_TH) && (gain_q != GAIN_MAX)) begin
                gain_q   <= gain_q + GAIN_ONE;
                locked_q <= 1'b0;
                state_q  <= ST_SETTLE;
                ready_q  <= 1'b0;
              end else begin
                locked_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tune_ready      = ready_q;
  assign phase_increment = phase_q;
  assign cic_gain        = gain_q;
  assign audio_valid     = av_q;
  assign audio           = audio_q;
  assign locked          = locked_q;

endmodule

// File: doc/am_tune_agc_ctrl.md
# am_tune_agc_ctrl

Control block that sits in front of the AM receiver and sequences its configuration. It accepts retune requests and drives `phase_increment` to the NCO. It runs a windowed-peak AGC on the demodulated output that steps `cic_gain` up or down. It blanks the audio stream while the CIC/demod pipeline settles after any retune or gain change, and reports lock once a full AGC window passes with no gain change.

## Interface
- `PHASE_WIDTH`, 64: NCO phase increment width.
- `DATA_WIDTH`, 12: demodulated sample width, signed.
- `CIC_GAIN_WIDTH`, 2: CIC gain select width. A larger value gives more gain.
- `GAIN_INIT`, 1: `cic_gain` value after reset and after every accepted retune.
- `SETTLE_SAMPLES`, 8: number of `demod_valid` samples discarded after a retune or gain change. Must be ≥1.
- `WIN_LOG2`, 4: the AGC window is 2^WIN_LOG2 valid samples.
- `AGC_HI`, 1536: if the window peak is ≥ this value, decrement gain.
- `AGC_LO`, 384: if the window peak is < this value, increment gain. Must be < `AGC_HI`.

Ports:
- `clk`  in  1  single clock.
- `arst`  in  1  asynchronous, active-low reset.
- `tune_req`  in  1  retune request. Held until accepted.
- `tune_phase_inc`  in  PHASE_WIDTH  new phase increment. Sampled on acceptance.
- `tune_ready`  out  1  controller can accept a retune.
- `phase_increment`  out  PHASE_WIDTH  to NCO.
- `cic_gain`  out  CIC_GAIN_WIDTH  to both CICs.
- `demod_valid`  in  1  demodulated sample strobe.
- `demod`  in  DATA_WIDTH  demodulated sample, signed.
- `audio_valid`  out  1  gated sample strobe.
- `audio`  out  DATA_WIDTH  gated sample.
- `locked`  out  1  AGC converged on the current channel.

## Operation
- FSM states: IDLE, SETTLE, RUN.
- Reset values: state IDLE, `phase_increment`=0, `cic_gain`=GAIN_INIT, `tune_ready`=1, `audio_valid`=0, `audio`=0, `locked`=0, settle and window counters 0, peak 0.
- A retune is accepted when `tune_req` and `tune_ready` are both high at a rising edge. `tune_ready` is 1 in IDLE and RUN and 0 in SETTLE.
- On acceptance, from IDLE or RUN:
  - latch `tune_phase_inc` into `phase_increment`
  - set `cic_gain`=GAIN_INIT and `locked`=0
  - clear the window counter and peak
  - load the settle counter and go to SETTLE.
- SETTLE: each `demod_valid` increments the settle counter. The sample that completes SETTLE_SAMPLES moves the FSM to RUN and is itself discarded. No audio is output in SETTLE.
- RUN:
  - Every `demod_valid` sample passes to `audio`.
  - |demod| is computed with saturation: -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1)-1. The running peak is the max of the current peak and |demod|.
  - The window counter increments per valid sample.
  - On the sample that completes the window, the peak (including that sample) is evaluated:
    - peak ≥ AGC_HI and gain > 0: gain-1, `locked`=0, go to SETTLE.
    - peak < AGC_LO and gain < 2^CIC_GAIN_WIDTH-1: gain+1, `locked`=0, go to SETTLE.
    - Otherwise, including at a gain limit: no gain change and `locked`=1.
  - In all three cases the peak and window counter are cleared.
  - The sample that ends the window is still forwarded to `audio`.
- Simultaneous retune acceptance and window end: the retune wins, and the gain evaluation is discarded.
- `tune_req` held while in SETTLE is accepted on the first cycle back in RUN.
- When `arst` is asserted mid-operation, all outputs return to their reset values immediately, asynchronously.

## Timing
- Retune: `phase_increment` and `cic_gain` update in the cycle after acceptance, and `tune_ready` drops in that same cycle.
- Audio path: one register stage. `audio_valid`/`audio` follow `demod_valid`/`demod` by 1 cycle when the FSM was in RUN on the input cycle.
- Gain step: `cic_gain` changes 1 cycle after the window-ending sample. The state is SETTLE from that cycle on.
- `locked` rises 1 cycle after the window-ending sample of a window that produced no gain change.

## Structure
- Shared package `am_rx_pkg`: state enum typedef, signed sample typedef parameterised on DATA_WIDTH, and a saturating-abs function.
- Sub-module `am_peak_window` holds the window counter, peak register and window-end strobe. It has inputs valid/sample/clear and outputs peak/done.
- FSM, counters and gain arithmetic live in the top. Gain is modified only by ±1 with explicit bounds checks, so it never wraps.

## Test plan
- Reset then idle: with `arst`=0, expect `phase_increment`=0, `cic_gain`=1, `tune_ready`=1, `locked`=0 and `audio_valid`=0 for any `demod_valid` activity.
- Retune to 0x0123_4567_89AB_CDEF: `phase_increment` updates the next cycle, and the first 8 valid samples produce no `audio_valid`. The 9th sample appears on `audio` 1 cycle later.
- Constant `demod`=2000 in RUN with gain 1: after 16 samples `cic_gain`=0 followed by an 8-sample blank. The next window stays at 0 because of the floor, and `locked`=1.
- Constant `demod`=-2048 (saturated abs = 2047): behaves as the high-amplitude case. Constant `demod`=100: gain steps 1→2→3, each step with an 8-sample blank, then `locked`=1 at gain 3.
- Peak between thresholds (`demod` alternating ±800): no gain change, `locked`=1 after the first 16-sample window.
- `tune_req` arriving on the window-ending cycle: the retune is accepted, `cic_gain`=1, no gain step, state SETTLE. Asserting `arst` mid-SETTLE returns all outputs to reset values.
